// File: rtl/key_remap_if.sv
// Signal bundle between the note-key front end and the remap table:
// physical keys and learn controls in, logical notes and prompt/learn status out.
interface key_remap_if #(
    parameter int NOTES    = 7,
    parameter int IDX_BITS = 3
);
    logic [NOTES-1:0]    note_key;
    logic                learn_start;
    logic                confirm;
    logic                learn_abort;
    logic                factory_reset;
    logic                prompt_busy;
    logic [NOTES-1:0]    trans_note;
    logic                prompt_req;
    logic [IDX_BITS-1:0] prompt_note;
    logic                learning;
    logic [IDX_BITS-1:0] learn_idx;
    logic                reject;
    logic                done;

    modport master (
        output note_key, learn_start, confirm, learn_abort, factory_reset, prompt_busy,
        input  trans_note, prompt_req, prompt_note, learning, learn_idx, reject, done
    );

    modport slave (
        input  note_key, learn_start, confirm, learn_abort, factory_reset, prompt_busy,
        output trans_note, prompt_req, prompt_note, learning, learn_idx, reject, done
    );
endinterface

// File: rtl/key_remap_table.sv
// Physical-to-logical note key remap table with a prompted learn sequence.
// A new table is built in a shadow copy and only replaces the live map once all notes are bound.
module key_remap_table #(
    parameter int NOTES          = 7,
    parameter int IDX_BITS       = 3,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input logic       clk,
    input logic       rst_n,
    key_remap_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PROMPT,
        WAIT_KEY,
        COMMIT
    } state_t;

    state_t state, next_state;

    logic [IDX_BITS-1:0] map    [NOTES];
    logic [IDX_BITS-1:0] shadow [NOTES];
    logic [NOTES-1:0]    used;
    logic [IDX_BITS-1:0] learn_idx;
    logic [CNT_W-1:0]    wait_cnt;
    logic [NOTES-1:0]    trans_note_p1;
    logic                reject_p1;
    logic                done_p1;

    logic [NOTES-1:0]    lookup;
    logic [IDX_BITS-1:0] key_idx;
    logic                key_ok;
    logic                timeout;
    logic                do_start, do_factory, do_abort, do_bind, do_reject, do_commit, cnt_clr;

    always_comb begin
        lookup = '0;
        for (int p = 0; p < NOTES; p++) begin
            if (bus.note_key[p]) lookup = lookup | (NOTES'(1) << map[p]);
        end
    end

    always_comb begin
        key_idx = '0;
        for (int p = 0; p < NOTES; p++) begin
            if (bus.note_key[p]) key_idx = IDX_BITS'(p);
        end
        key_ok = $onehot(bus.note_key) && !used[key_idx];
    end

    // A zero TIMEOUT_CYCLES leaves the session waiting for a key indefinitely.
    assign timeout = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_start   = 1'b0;
        do_factory = 1'b0;
        do_abort   = 1'b0;
        do_bind    = 1'b0;
        do_reject  = 1'b0;
        do_commit  = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.learn_start) begin
                    do_start   = 1'b1;
                    next_state = PROMPT;
                end else if (bus.factory_reset) begin
                    do_factory = 1'b1;
                end
            end
            PROMPT: begin
                if (bus.learn_abort) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_clr    = 1'b1;
                    next_state = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (bus.learn_abort || timeout) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else if (bus.confirm && !bus.prompt_busy) begin
                    if (key_ok) begin
                        do_bind    = 1'b1;
                        next_state = (learn_idx == IDX_BITS'(NOTES - 1)) ? COMMIT : PROMPT;
                    end else begin
                        do_reject  = 1'b1;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (bus.learn_abort) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else begin
                    do_commit  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NOTES; p++) begin
                map[p]    <= IDX_BITS'(p);
                shadow[p] <= '0;
            end
            used          <= '0;
            learn_idx     <= '0;
            wait_cnt      <= '0;
            trans_note_p1 <= '0;
            reject_p1     <= 1'b0;
            done_p1       <= 1'b0;
        end else begin
            trans_note_p1 <= (state == IDLE) ? lookup : '0;
            reject_p1     <= do_reject;
            done_p1       <= do_commit;

            if (cnt_clr)               wait_cnt <= '0;
            else if (state == WAIT_KEY) wait_cnt <= wait_cnt + CNT_W'(1);

            if (do_start) begin
                for (int p = 0; p < NOTES; p++) shadow[p] <= '0;
                used      <= '0;
                learn_idx <= '0;
            end
            if (do_factory) begin
                for (int p = 0; p < NOTES; p++) map[p] <= IDX_BITS'(p);
            end
            if (do_abort) learn_idx <= '0;
            if (do_bind) begin
                shadow[key_idx] <= learn_idx;
                used[key_idx]   <= 1'b1;
                learn_idx       <= learn_idx + IDX_BITS'(1);
            end
            // Whole table swaps in one edge, so the live map is never half-learned.
            if (do_commit) begin
                for (int p = 0; p < NOTES; p++) map[p] <= shadow[p];
                learn_idx <= '0;
            end
        end
    end

    assign bus.learning    = (state != IDLE);
    assign bus.trans_note  = bus.learning ? '0 : trans_note_p1;
    assign bus.prompt_req  = (state == PROMPT);
    assign bus.prompt_note = learn_idx;
    assign bus.learn_idx   = learn_idx;
    assign bus.reject      = reject_p1;
    assign bus.done        = done_p1;
endmodule

// File: tb/tb_key_remap_table.sv
// Randomized bench for key_remap_table; a permutation model of the live map predicts lookups.
module tb_key_remap_table;
    localparam int NOTES = 7;
    localparam int IDX_BITS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_remap_if #(.NOTES(NOTES), .IDX_BITS(IDX_BITS)) kif ();

    key_remap_table #(.NOTES(NOTES), .IDX_BITS(IDX_BITS), .TIMEOUT_CYCLES(100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (kif)
    );

    int checks = 0;
    int errors = 0;
    int mdl_map [NOTES];
    int ord [NOTES];
    int prompt_q [$];
    int done_cnt = 0;
    int rej_cnt = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (kif.prompt_req) prompt_q.push_back(int'(kif.prompt_note));
            if (kif.done) done_cnt++;
            if (kif.reject) rej_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lookup(input logic [NOTES-1:0] key);
        int r = 0;
        for (int p = 0; p < NOTES; p++) if (key[p]) r = r | (1 << mdl_map[p]);
        return r;
    endfunction

    task automatic model_identity();
        for (int p = 0; p < NOTES; p++) mdl_map[p] = p;
    endtask

    task automatic lookup_rand(input int n);
        for (int k = 0; k < n; k++) begin
            kif.note_key = NOTES'($urandom_range(0, 127));
            tick();
            check_eq("lookup", int'(kif.trans_note), exp_lookup(kif.note_key));
        end
    endtask

    task automatic shuffle_ord();
        int j, t;
        for (int i = 0; i < NOTES; i++) ord[i] = i;
        for (int i = NOTES - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
    endtask

    task automatic bad_confirm(input logic [NOTES-1:0] key, input int idx);
        kif.note_key = key;
        kif.confirm = 1'b1;
        tick();
        kif.confirm = 1'b0;
        check_eq("reject_bad", int'(kif.reject), 1);
        check_eq("idx_after_bad", int'(kif.learn_idx), idx);
    endtask

    // Caller must be in PROMPT; leaves the session in the state after the bind.
    task automatic bind_key(input int p);
        tick();
        kif.note_key = NOTES'(1 << p);
        kif.confirm = 1'b1;
        tick();
        kif.confirm = 1'b0;
    endtask

    task automatic run_session(input bit force_bad, input bit inject);
        int d0, r0, nb, a, b;
        d0 = done_cnt;
        prompt_q.delete();
        kif.learn_start = 1'b1;
        tick();
        kif.learn_start = 1'b0;
        check_eq("learning_start", int'(kif.learning), 1);
        for (int i = 0; i < NOTES; i++) begin
            tick();
            kif.prompt_busy = 1'b1;
            nb = $urandom_range(1, 4);
            for (int c = 0; c < nb; c++) begin
                if (c == 0) begin
                    r0 = rej_cnt;
                    kif.note_key = NOTES'(1 << ord[i]);
                    kif.confirm = 1'b1;
                end
                tick();
                kif.confirm = 1'b0;
                if (c == 0) check_eq("busy_no_bind", int'(kif.learn_idx), i);
            end
            tick();
            check_eq("busy_no_reject", rej_cnt, r0);
            kif.prompt_busy = 1'b0;
            if (force_bad && i == 1) begin
                bad_confirm(7'b0000011, i);
                bad_confirm(NOTES'(1 << ord[0]), i);
            end else if (inject && $urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 6);
                b = (a + 1 + $urandom_range(0, 5)) % NOTES;
                case ($urandom_range(0, 2))
                    0: bad_confirm('0, i);
                    1: bad_confirm(NOTES'((1 << a) | (1 << b)), i);
                    default: bad_confirm((i > 0) ? NOTES'(1 << ord[$urandom_range(0, i - 1)]) : '0, i);
                endcase
            end
            kif.note_key = NOTES'(1 << ord[i]);
            kif.confirm = 1'b1;
            tick();
            kif.confirm = 1'b0;
            check_eq("idx_after_bind", int'(kif.learn_idx), i + 1);
            check_eq("reject_on_good", int'(kif.reject), 0);
        end
        tick();
        check_eq("done_pulse", int'(kif.done), 1);
        check_eq("learning_end", int'(kif.learning), 0);
        check_eq("idx_end", int'(kif.learn_idx), 0);
        kif.note_key = '0;
        tick();
        check_eq("done_single", done_cnt - d0, 1);
        check_eq("prompt_count", prompt_q.size(), NOTES);
        for (int i = 0; i < prompt_q.size() && i < NOTES; i++) check_eq("prompt_note", prompt_q[i], i);
        for (int i = 0; i < NOTES; i++) mdl_map[ord[i]] = i;
    endtask

    initial begin
        int d0;
        kif.note_key = '0;
        kif.learn_start = 1'b0;
        kif.confirm = 1'b0;
        kif.learn_abort = 1'b0;
        kif.factory_reset = 1'b0;
        kif.prompt_busy = 1'b0;
        model_identity();
        #12;
        check_eq("rst_trans", int'(kif.trans_note), 0);
        check_eq("rst_learning", int'(kif.learning), 0);
        check_eq("rst_prompt_req", int'(kif.prompt_req), 0);
        rst_n = 1'b1;
        tick();
        kif.note_key = 7'b0000100;
        tick();
        check_eq("ident_lookup", int'(kif.trans_note), 4);
        check_eq("ident_learning", int'(kif.learning), 0);
        check_eq("ident_done", int'(kif.done), 0);
        lookup_rand(5);

        // abort racing a valid confirm after three binds
        d0 = done_cnt;
        kif.learn_start = 1'b1;
        tick();
        kif.learn_start = 1'b0;
        for (int i = 0; i < 3; i++) bind_key(6 - i);
        tick();
        kif.note_key = 7'b0000001;
        kif.confirm = 1'b1;
        kif.learn_abort = 1'b1;
        tick();
        kif.confirm = 1'b0;
        kif.learn_abort = 1'b0;
        check_eq("abort_learning", int'(kif.learning), 0);
        check_eq("abort_idx", int'(kif.learn_idx), 0);
        tick();
        check_eq("abort_no_done", done_cnt - d0, 0);
        lookup_rand(6);

        for (int i = 0; i < NOTES; i++) ord[i] = 6 - i;
        run_session(1'b1, 1'b0);
        kif.note_key = 7'b1000000;
        tick();
        check_eq("rev_lookup", int'(kif.trans_note), 1);
        lookup_rand(6);

        for (int s = 0; s < 3; s++) begin
            shuffle_ord();
            run_session(1'b0, 1'b1);
            lookup_rand(8);
        end

        // learn_start beats factory_reset, then abort from PROMPT keeps the map
        kif.learn_start = 1'b1;
        kif.factory_reset = 1'b1;
        tick();
        kif.learn_start = 1'b0;
        kif.factory_reset = 1'b0;
        check_eq("start_wins", int'(kif.learning), 1);
        kif.learn_abort = 1'b1;
        tick();
        kif.learn_abort = 1'b0;
        check_eq("prompt_abort", int'(kif.learning), 0);
        lookup_rand(6);

        kif.factory_reset = 1'b1;
        tick();
        kif.factory_reset = 1'b0;
        model_identity();
        lookup_rand(6);

        // timeout after 100 idle cycles in WAIT_KEY
        shuffle_ord();
        run_session(1'b0, 1'b0);
        d0 = done_cnt;
        kif.learn_start = 1'b1;
        tick();
        kif.learn_start = 1'b0;
        tick();
        repeat (99) tick();
        check_eq("timeout_pending", int'(kif.learning), 1);
        tick();
        check_eq("timeout_idle", int'(kif.learning), 0);
        check_eq("timeout_idx", int'(kif.learn_idx), 0);
        check_eq("timeout_no_done", done_cnt - d0, 0);
        lookup_rand(6);

        // asynchronous reset in the middle of a session
        kif.learn_start = 1'b1;
        tick();
        kif.learn_start = 1'b0;
        bind_key(ord[0]);
        bind_key(ord[1]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_learning", int'(kif.learning), 0);
        check_eq("arst_idx", int'(kif.learn_idx), 0);
        check_eq("arst_prompt_req", int'(kif.prompt_req), 0);
        check_eq("arst_prompt_note", int'(kif.prompt_note), 0);
        check_eq("arst_trans", int'(kif.trans_note), 0);
        check_eq("arst_reject", int'(kif.reject), 0);
        check_eq("arst_done", int'(kif.done), 0);
        tick();
        rst_n = 1'b1;
        model_identity();
        lookup_rand(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
